heat_snapshot_uart: RTL

Downstream readout stage for the 5x5 heat-equation solver. On request it scans all 25 cells through the solver's read port into a local snapshot buffer, then streams the snapshot off-chip as a framed 8N1 UART packet: sync byte, packed temperatures, checksum. Capture is fast (25 cycles), so the solver leaves Run mode only briefly. Transmission runs from the frozen snapshot.

---
 rtl/heat_pkg.sv | 14 +
 rtl/heat_snapshot_uart_if.sv | 17 +
 rtl/heat_snapshot_uart_tx.sv | 54 +++++
 rtl/heat_snapshot_uart.sv | 111 +++++++++++
 4 files changed

// File: rtl/heat_pkg.sv
// Shared constants and FSM encoding for the 5x5 heat solver and its snapshot readout.
package heat_pkg;
  localparam int unsigned GRID_CELLS  = 25;
  localparam int unsigned TEMP_W      = 4;
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 15;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND,
    FINISH
  } state_t;
endpackage

// File: rtl/heat_snapshot_uart_if.sv
// Request, solver read port and UART status bundle for the snapshot readout stage.
interface heat_snapshot_uart_if;
  import heat_pkg::*;

  logic              start;
  logic              rd_req;
  logic [4:0]        rd_addr;
  logic [TEMP_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              tx;

  modport master (output start, output rd_data, input rd_req, input rd_addr,
                  input busy, input done, input tx);
  modport slave  (input start, input rd_data, output rd_req, output rd_addr,
                  output busy, output done, output tx);
endinterface

// File: rtl/heat_snapshot_uart_tx.sv
// 8N1 UART transmitter; ready also rises in the final stop-bit cycle so bytes chain gap-free.
module uart_tx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       ready
);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          r_active;
  logic          w_bit_end;

  assign w_bit_end = r_active && (r_baud == BAUD_LAST);
  assign ready     = !r_active || (w_bit_end && (r_bit == 4'd9));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      r_active <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '1;
    end else if (load && ready) begin
      tx       <= 1'b0;
      r_shift  <= {1'b1, data};
      r_baud   <= '0;
      r_bit    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
          tx       <= 1'b1;
        end else begin
          // The stop bit falls out of the shifter's top after the eighth data bit.
          r_bit   <= r_bit + 4'd1;
          tx      <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_baud <= r_baud + BW'(1);
      end
    end
  end
endmodule

// File: rtl/heat_snapshot_uart.sv
// Snapshots the solver grid through its read port, then streams it as a framed UART packet.
module heat_snapshot_uart #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned GRID_CELLS   = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  heat_snapshot_uart_if.slave  bus
);
  import heat_pkg::*;

  localparam logic [4:0] LAST_ADDR = 5'(GRID_CELLS - 1);
  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

  state_t            r_state;
  logic              r_rd_req;
  logic [4:0]        r_rd_addr;
  logic              r_busy;
  logic              r_done;
  logic [3:0]        r_byte_idx;
  logic [7:0]        r_csum;
  logic [TEMP_W-1:0] r_snap [GRID_CELLS];

  logic       w_ready;
  logic       w_load;
  logic       w_tx;
  logic [7:0] w_tx_data;
  logic [4:0] w_lo_idx;
  logic [4:0] w_hi_idx;

  // r_byte_idx is the byte on the line; the mux prepares byte r_byte_idx+1.
  assign w_lo_idx = {r_byte_idx, 1'b0};
  assign w_hi_idx = {r_byte_idx, 1'b1};

  always_comb begin
    w_tx_data = SYNC_BYTE;
    if (r_state == SEND) begin
      if (r_byte_idx < 4'd12)       w_tx_data = {r_snap[w_hi_idx], r_snap[w_lo_idx]};
      else if (r_byte_idx == 4'd12) w_tx_data = {4'h0, r_snap[w_lo_idx]};
      else                          w_tx_data = r_csum;
    end
  end

  assign w_load = ((r_state == CAPTURE) && (r_rd_addr == LAST_ADDR)) ||
                  ((r_state == SEND) && w_ready && (r_byte_idx != LAST_BYTE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_idx <= '0;
      r_csum     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= CAPTURE;
            r_rd_req  <= 1'b1;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          r_snap[r_rd_addr] <= bus.rd_data;
          if (r_rd_addr == LAST_ADDR) begin
            r_state    <= SEND;
            r_rd_req   <= 1'b0;
            r_rd_addr  <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
          end else begin
            r_rd_addr <= r_rd_addr + 5'd1;
          end
        end
        SEND: begin
          if (w_ready) begin
            if (r_byte_idx == LAST_BYTE) begin
              r_state <= FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 4'd1;
              if (r_byte_idx < 4'd13) r_csum <= r_csum ^ w_tx_data;
            end
          end
        end
        FINISH: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (w_tx_data),
    .load  (w_load),
    .tx    (w_tx),
    .ready (w_ready)
  );

  assign bus.rd_req  = r_rd_req;
  assign bus.rd_addr = r_rd_addr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.tx      = w_tx;
endmodule
